// File: rtl/core_hazard_pkg.sv
// Shared encodings for the Selen pipeline hazard controller.
package core_hazard_pkg;

  // Hazard class of the instruction currently in EXE
  typedef enum logic [1:0] {
    HZRD_OTHER = 2'b00,
    HZRD_BRNCH = 2'b01,
    HZRD_JUMP  = 2'b10,
    HZRD_LOAD  = 2'b11
  } hz_type_e;

  // EXE operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StImiss = 2'b01,
    StDmiss = 2'b10
  } hz_state_e;

  // Hazard bus layout: {rs1, rs2, rd}
  localparam int unsigned REG_W      = 5;
  localparam int unsigned HZ_BUS_W   = 3 * REG_W;
  localparam int unsigned HZ_RS1_LSB = 2 * REG_W;
  localparam int unsigned HZ_RS2_LSB = REG_W;
  localparam int unsigned HZ_RD_LSB  = 0;

endpackage

// File: rtl/core_hazard_fwd.sv
// Forwarding source select for one EXE source operand.
module core_hazard_fwd
  import core_hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_we,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_we,
  output logic [1:0]       o_sel
);

  // MEM holds the newer value, so it wins over WB; x0 is never forwarded
  always_comb begin
    o_sel = FWD_RF;
    if (i_rs != '0) begin
      if (i_mem_we && (i_mem_rd == i_rs)) begin
        o_sel = FWD_MEM;
      end else if (i_wb_we && (i_wb_rd == i_rs)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/core_hazard_ctrl.sv
// Pipeline sequencing for the five-stage Selen core: stage enables, kills,
// bubble injection, PC redirect, operand forwarding and stall/flush counters.
module core_hazard_ctrl
  import core_hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HZ_BUS_W-1:0] hz_dec_bus,
  input  logic [HZ_BUS_W-1:0] hz_exe_bus,
  input  logic [1:0]          hz_exe_type,
  input  logic                hz_exe_we,
  input  logic [REG_W-1:0]    hz_mem_rd,
  input  logic                hz_mem_we,
  input  logic [REG_W-1:0]    hz_wb_rd,
  input  logic                hz_wb_we,
  input  logic                exe_brnch_taken,
  input  logic                il1_ack,
  input  logic                dl1_req,
  input  logic                dl1_ack,
  output logic                pc_enb,
  output logic                if_enb,
  output logic                if_kill,
  output logic                dec_enb,
  output logic                dec_nop_gen,
  output logic                dec_kill,
  output logic                exe_enb,
  output logic                mem_enb,
  output logic                pc_sel,
  output logic [1:0]          fwd_src1_sel,
  output logic [1:0]          fwd_src2_sel,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  hz_state_e        r_state;
  logic             r_drop_pend;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [REG_W-1:0] w_dec_rs1, w_dec_rs2;
  logic [REG_W-1:0] w_exe_rs1, w_exe_rs2, w_exe_rd;
  logic [1:0]       w_fwd1, w_fwd2;
  logic             w_redir, w_dmiss, w_load_use, w_imiss;
  logic             w_unused_dec_rd;

  assign w_dec_rs1 = hz_dec_bus[HZ_RS1_LSB +: REG_W];
  assign w_dec_rs2 = hz_dec_bus[HZ_RS2_LSB +: REG_W];
  assign w_exe_rs1 = hz_exe_bus[HZ_RS1_LSB +: REG_W];
  assign w_exe_rs2 = hz_exe_bus[HZ_RS2_LSB +: REG_W];
  assign w_exe_rd  = hz_exe_bus[HZ_RD_LSB +: REG_W];

  // The DEC destination plays no part in any hazard decision
  assign w_unused_dec_rd = ^hz_dec_bus[HZ_RD_LSB +: REG_W];

  assign w_redir = (hz_exe_type == HZRD_JUMP) ||
                   ((hz_exe_type == HZRD_BRNCH) && exe_brnch_taken);
  // Once in DMISS only the ack releases, regardless of dl1_req
  assign w_dmiss = (r_state == StDmiss) || (dl1_req && !dl1_ack);
  assign w_load_use = (hz_exe_type == HZRD_LOAD) && hz_exe_we && (w_exe_rd != '0) &&
                      ((w_exe_rd == w_dec_rs1) || (w_exe_rd == w_dec_rs2));
  assign w_imiss = !il1_ack;

  core_hazard_fwd u_fwd_src1 (
    .i_rs     (w_exe_rs1),
    .i_mem_rd (hz_mem_rd),
    .i_mem_we (hz_mem_we),
    .i_wb_rd  (hz_wb_rd),
    .i_wb_we  (hz_wb_we),
    .o_sel    (w_fwd1)
  );

  core_hazard_fwd u_fwd_src2 (
    .i_rs     (w_exe_rs2),
    .i_mem_rd (hz_mem_rd),
    .i_mem_we (hz_mem_we),
    .i_wb_rd  (hz_wb_rd),
    .i_wb_we  (hz_wb_we),
    .o_sel    (w_fwd2)
  );

  // Control outputs, resolved in priority order: reset, DMISS, redirect, load-use/IMISS
  always_comb begin
    pc_enb       = 1'b1;
    if_enb       = 1'b1;
    dec_enb      = 1'b1;
    exe_enb      = 1'b1;
    mem_enb      = 1'b1;
    if_kill      = 1'b0;
    dec_kill     = 1'b0;
    dec_nop_gen  = 1'b0;
    pc_sel       = 1'b0;
    fwd_src1_sel = w_fwd1;
    fwd_src2_sel = w_fwd2;
    if (rst) begin
      if_kill      = 1'b1;
      dec_kill     = 1'b1;
      fwd_src1_sel = FWD_RF;
      fwd_src2_sel = FWD_RF;
    end else if (w_dmiss) begin
      // Whole pipe frozen until the ack; a pending redirect waits one more cycle
      pc_enb  = dl1_ack;
      if_enb  = dl1_ack;
      dec_enb = dl1_ack;
      exe_enb = dl1_ack;
      mem_enb = dl1_ack;
    end else if (w_redir) begin
      pc_sel   = 1'b1;
      if_kill  = 1'b1;
      dec_kill = 1'b1;
    end else if (w_load_use || w_imiss) begin
      pc_enb      = 1'b0;
      if_enb      = 1'b0;
      dec_nop_gen = 1'b1;
    end else if ((r_state == StImiss) && r_drop_pend) begin
      // Fetch returned for a PC that was redirected away while it was in flight
      if_kill = 1'b1;
    end
  end

  // Miss tracking FSM and stale-fetch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_drop_pend <= 1'b0;
    end else if (w_dmiss) begin
      r_state <= dl1_ack ? StRun : StDmiss;
    end else begin
      r_state <= il1_ack ? StRun : StImiss;
      if (r_state == StImiss) begin
        if (il1_ack) begin
          r_drop_pend <= 1'b0;
        end else if (w_redir) begin
          r_drop_pend <= 1'b1;
        end
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_enb && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (pc_sel && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed bench for core_hazard_ctrl with a behavioural reference model.
module tb_core_hazard_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef struct packed {
    logic       pc_enb;
    logic       if_enb;
    logic       if_kill;
    logic       dec_enb;
    logic       dec_nop_gen;
    logic       dec_kill;
    logic       exe_enb;
    logic       mem_enb;
    logic       pc_sel;
    logic [1:0] f1;
    logic [1:0] f2;
  } ctrl_t;

  logic        clk;
  logic        rst;
  logic [14:0] dec_bus, exe_bus;
  logic [1:0]  exe_type;
  logic        exe_we, mem_we, wb_we, taken, il1_ack, dl1_req, dl1_ack;
  logic [4:0]  mem_rd, wb_rd;

  logic        pc_enb, if_enb, if_kill, dec_enb, dec_nop_gen, dec_kill;
  logic        exe_enb, mem_enb, pc_sel;
  logic [1:0]  fwd_src1_sel, fwd_src2_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;

  // Reference model state
  logic          m_dmiss, m_imiss, m_drop;
  logic [CW-1:0] m_stall, m_flush;
  logic          m_hold;
  ctrl_t         m_exp;

  core_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hz_dec_bus      (dec_bus),
    .hz_exe_bus      (exe_bus),
    .hz_exe_type     (exe_type),
    .hz_exe_we       (exe_we),
    .hz_mem_rd       (mem_rd),
    .hz_mem_we       (mem_we),
    .hz_wb_rd        (wb_rd),
    .hz_wb_we        (wb_we),
    .exe_brnch_taken (taken),
    .il1_ack         (il1_ack),
    .dl1_req         (dl1_req),
    .dl1_ack         (dl1_ack),
    .pc_enb          (pc_enb),
    .if_enb          (if_enb),
    .if_kill         (if_kill),
    .dec_enb         (dec_enb),
    .dec_nop_gen     (dec_nop_gen),
    .dec_kill        (dec_kill),
    .exe_enb         (exe_enb),
    .mem_enb         (mem_enb),
    .pc_sel          (pc_sel),
    .fwd_src1_sel    (fwd_src1_sel),
    .fwd_src2_sel    (fwd_src2_sel),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd);
    return {rs1, rs2, rd};
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (mem_we && mem_rd == rs) return 2'b01;
    if (wb_we && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Expected outputs from the current model state and inputs
  function automatic ctrl_t model_ctrl();
    ctrl_t c;
    logic redirect, load_use, release_c;
    logic [4:0] erd;
    erd = exe_bus[4:0];
    c = '0;
    {c.pc_enb, c.if_enb, c.dec_enb, c.exe_enb, c.mem_enb} = 5'b11111;
    c.f1 = fwd_of(exe_bus[14:10]);
    c.f2 = fwd_of(exe_bus[9:5]);
    if (rst) begin
      c.if_kill = 1'b1;
      c.dec_kill = 1'b1;
      c.f1 = 2'b00;
      c.f2 = 2'b00;
      return c;
    end
    redirect  = (exe_type == 2'b10) || (exe_type == 2'b01 && taken);
    load_use  = (exe_type == 2'b11) && exe_we && erd != 5'd0 &&
                (erd == dec_bus[14:10] || erd == dec_bus[9:5]);
    release_c = m_dmiss && dl1_ack;
    if (m_hold) begin
      {c.pc_enb, c.if_enb, c.dec_enb, c.exe_enb, c.mem_enb} = 5'b00000;
    end else if (release_c) begin
      c.pc_sel = 1'b0;
    end else if (redirect) begin
      c.pc_sel = 1'b1;
      c.if_kill = 1'b1;
      c.dec_kill = 1'b1;
    end else if (load_use || !il1_ack) begin
      c.pc_enb = 1'b0;
      c.if_enb = 1'b0;
      c.dec_nop_gen = 1'b1;
    end else if (m_imiss && m_drop) begin
      c.if_kill = 1'b1;
    end
    return c;
  endfunction

  always_comb m_hold = !rst && (m_dmiss ? !dl1_ack : (dl1_req && !dl1_ack));
  always_comb m_exp = model_ctrl();

  // Model state advance
  always @(posedge clk) begin
    if (rst) begin
      m_dmiss <= 1'b0;
      m_imiss <= 1'b0;
      m_drop  <= 1'b0;
      m_stall <= '0;
      m_flush <= '0;
    end else begin
      if (!m_exp.pc_enb && m_stall != CMAX) m_stall <= m_stall + 1'b1;
      if (m_exp.pc_sel && m_flush != CMAX) m_flush <= m_flush + 1'b1;
      if (m_hold) begin
        m_dmiss <= 1'b1;
        m_imiss <= 1'b0;
      end else if (m_dmiss) begin
        m_dmiss <= 1'b0;
        m_imiss <= 1'b0;
      end else begin
        m_imiss <= !il1_ack;
        if (m_imiss) begin
          if (il1_ack) m_drop <= 1'b0;
          else if ((exe_type == 2'b10) || (exe_type == 2'b01 && taken)) m_drop <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("pc_enb", pc_enb, m_exp.pc_enb);
      chk("if_enb", if_enb, m_exp.if_enb);
      chk("if_kill", if_kill, m_exp.if_kill);
      chk("dec_enb", dec_enb, m_exp.dec_enb);
      chk("dec_nop_gen", dec_nop_gen, m_exp.dec_nop_gen);
      chk("dec_kill", dec_kill, m_exp.dec_kill);
      chk("exe_enb", exe_enb, m_exp.exe_enb);
      chk("mem_enb", mem_enb, m_exp.mem_enb);
      chk("pc_sel", pc_sel, m_exp.pc_sel);
      chk("fwd_src1_sel", fwd_src1_sel, m_exp.f1);
      chk("fwd_src2_sel", fwd_src2_sel, m_exp.f2);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end
  end

  task automatic idle();
    rst = 1'b0; dec_bus = '0; exe_bus = '0; exe_type = 2'b00; exe_we = 1'b0;
    mem_rd = '0; mem_we = 1'b0; wb_rd = '0; wb_we = 1'b0; taken = 1'b0;
    il1_ack = 1'b1; dl1_req = 1'b0; dl1_ack = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    advance();
    check_en = 1'b1;

    // Reset forcing
    rst = 1'b1;
    settle();
    chk("rst_if_kill", if_kill, 1);
    chk("rst_dec_kill", dec_kill, 1);
    chk("rst_pc_enb", pc_enb, 1);
    advance();
    idle();
    settle();
    chk("post_rst_stall", stall_cnt, 0);
    chk("post_rst_flush", flush_cnt, 0);
    chk("post_rst_if_kill", if_kill, 0);
    advance();

    // Load-use: one bubble, then WB forwarding
    idle(); exe_bus = mk(5'd1, 5'd2, 5'd5); exe_type = 2'b11; exe_we = 1'b1;
    dec_bus = mk(5'd3, 5'd5, 5'd9);
    settle();
    chk("lu_pc_enb", pc_enb, 0);
    chk("lu_if_enb", if_enb, 0);
    chk("lu_nop", dec_nop_gen, 1);
    chk("lu_dec_enb", dec_enb, 1);
    advance();
    idle(); mem_rd = 5'd5; mem_we = 1'b1; dec_bus = mk(5'd3, 5'd5, 5'd9);
    settle();
    chk("lu_bubble_pc_enb", pc_enb, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    advance();
    idle(); exe_bus = mk(5'd3, 5'd5, 5'd9); exe_we = 1'b1; wb_rd = 5'd5; wb_we = 1'b1;
    settle();
    chk("lu_fwd2_wb", fwd_src2_sel, 2'b10);
    chk("lu_fwd1_rf", fwd_src1_sel, 2'b00);
    advance();
    // Load to x0, and a non-writing load, never stall
    idle(); exe_bus = mk(5'd0, 5'd0, 5'd0); exe_type = 2'b11; exe_we = 1'b1;
    settle();
    chk("lu_x0_pc_enb", pc_enb, 1);
    advance();
    idle(); exe_bus = mk(5'd0, 5'd0, 5'd4); exe_type = 2'b11; dec_bus = mk(5'd4, 5'd0, 5'd0);
    settle();
    chk("lu_nowe_pc_enb", pc_enb, 1);
    advance();

    // Forwarding priority
    idle(); exe_bus = mk(5'd7, 5'd0, 5'd0); mem_rd = 5'd7; mem_we = 1'b1;
    wb_rd = 5'd7; wb_we = 1'b1;
    settle();
    chk("fwd_mem_prio", fwd_src1_sel, 2'b01);
    advance();
    mem_we = 1'b0;
    settle();
    chk("fwd_wb", fwd_src1_sel, 2'b10);
    advance();
    exe_bus = mk(5'd0, 5'd7, 5'd0); mem_we = 1'b1;
    settle();
    chk("fwd_x0", fwd_src1_sel, 2'b00);
    chk("fwd2_mem", fwd_src2_sel, 2'b01);
    advance();

    // Taken and not-taken branch
    idle(); exe_type = 2'b01; taken = 1'b1;
    settle();
    chk("br_pc_sel", pc_sel, 1);
    chk("br_if_kill", if_kill, 1);
    chk("br_dec_kill", dec_kill, 1);
    advance();
    idle(); exe_type = 2'b01; taken = 1'b0;
    settle();
    chk("br_nt_pc_sel", pc_sel, 0);
    chk("br_nt_if_kill", if_kill, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    advance();

    // Redirect during fetch miss
    idle(); il1_ack = 1'b0;
    settle();
    chk("im1_pc_enb", pc_enb, 0);
    chk("im1_nop", dec_nop_gen, 1);
    chk("im1_exe_enb", exe_enb, 1);
    advance();
    idle(); il1_ack = 1'b0; exe_type = 2'b10;
    settle();
    chk("im2_pc_sel", pc_sel, 1);
    chk("im2_pc_enb", pc_enb, 1);
    advance();
    idle(); il1_ack = 1'b0;
    settle();
    chk("im3_pc_enb", pc_enb, 0);
    chk("im3_if_kill", if_kill, 0);
    advance();
    idle();
    settle();
    chk("im4_drop_kill", if_kill, 1);
    chk("im4_dec_kill", dec_kill, 0);
    chk("im4_pc_enb", pc_enb, 1);
    advance();
    idle();
    settle();
    chk("im5_if_kill", if_kill, 0);
    chk("im5_stall", stall_cnt, 3);
    chk("im5_flush", flush_cnt, 2);
    advance();

    // Data miss overrides a pending jump
    for (int i = 0; i < 4; i++) begin
      idle(); exe_type = 2'b10; dl1_req = 1'b1;
      settle();
      chk("dm_pc_enb", pc_enb, 0);
      chk("dm_mem_enb", mem_enb, 0);
      chk("dm_pc_sel", pc_sel, 0);
      chk("dm_if_kill", if_kill, 0);
      advance();
    end
    idle(); exe_type = 2'b10; dl1_req = 1'b1; dl1_ack = 1'b1;
    settle();
    chk("dm_ack_pc_enb", pc_enb, 1);
    chk("dm_ack_pc_sel", pc_sel, 0);
    advance();
    idle(); exe_type = 2'b10;
    settle();
    chk("dm_after_pc_sel", pc_sel, 1);
    advance();
    idle();
    settle();
    chk("dm_flush", flush_cnt, 3);
    chk("dm_stall", stall_cnt, 7);
    advance();

    // Reset in the middle of a data miss
    for (int i = 0; i < 2; i++) begin
      idle(); dl1_req = 1'b1;
      settle();
      advance();
    end
    idle(); dl1_req = 1'b1; rst = 1'b1;
    settle();
    chk("rdm_pc_enb", pc_enb, 1);
    chk("rdm_if_kill", if_kill, 1);
    chk("rdm_stall_pre", stall_cnt, 9);
    advance();
    idle();
    settle();
    chk("rdm_mem_enb", mem_enb, 1);
    chk("rdm_stall", stall_cnt, 0);
    chk("rdm_flush", flush_cnt, 0);
    advance();

    // Reset during fetch miss with a stale fetch pending
    idle(); il1_ack = 1'b0;
    settle(); advance();
    idle(); il1_ack = 1'b0; exe_type = 2'b10;
    settle(); advance();
    idle(); il1_ack = 1'b0; rst = 1'b1;
    settle(); advance();
    idle();
    settle();
    chk("rim_if_kill", if_kill, 0);
    advance();

    // Counter saturation
    for (int i = 0; i < 18; i++) begin
      idle(); il1_ack = 1'b0;
      settle(); advance();
    end
    idle();
    settle();
    chk("sat_stall", stall_cnt, 15);
    advance();
    for (int i = 0; i < 17; i++) begin
      idle(); exe_type = 2'b10;
      settle(); advance();
    end
    idle();
    settle();
    chk("sat_flush", flush_cnt, 15);
    chk("sat_stall_hold", stall_cnt, 15);
    advance();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_hazard_ctrl.md
Name: core_hazard_ctrl

Overview:
- Pipeline sequencing unit for the five-stage Selen core (IF, DEC, EXE, MEM, WB).
- Consumes the per-stage hazard bus and hazard type produced by decode, plus the L1 cache acknowledges and the EXE branch outcome.
- Generates all stage enables, kills, NOP injection, the PC redirect select and the EXE operand forwarding selects.
- Counts stall and flush cycles for performance monitoring.

Parameters:
- CNT_W, 32, width of the saturating stall and flush counters.

Ports:
- clk  in  1  system clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- hz_dec_bus  in  15  {rs1,rs2,rd} of the instruction currently in DEC.
- hz_exe_bus  in  15  {rs1,rs2,rd} registered into EXE.
- hz_exe_type  in  2  hazard type of the EXE instruction: OTHER=00, BRNCH=01, JUMP=10, LOAD=11.
- hz_exe_we  in  1  EXE instruction writes the register file.
- hz_mem_rd  in  5  MEM-stage destination register.
- hz_mem_we  in  1  MEM-stage write enable.
- hz_wb_rd  in  5  WB-stage destination register.
- hz_wb_we  in  1  WB-stage write enable.
- exe_brnch_taken  in  1  branch condition true; qualified by hz_exe_type==BRNCH.
- il1_ack  in  1  instruction fetch data valid this cycle.
- dl1_req  in  1  MEM stage holds a valid data cache request.
- dl1_ack  in  1  data cache response for that request.
- pc_enb  out  1  PC register update enable.
- if_enb  out  1  IF/DEC register load enable.
- if_kill  out  1  clear IF/DEC register.
- dec_enb  out  1  DEC/EXE register load enable.
- dec_nop_gen  out  1  DEC/EXE register loads a bubble.
- dec_kill  out  1  clear DEC/EXE register.
- exe_enb  out  1  EXE/MEM register load enable.
- mem_enb  out  1  MEM/WB register load enable.
- pc_sel  out  1  1 selects the EXE branch/jump target.
- fwd_src1_sel  out  2  00 register file, 01 MEM result, 10 WB result.
- fwd_src2_sel  out  2  same encoding as fwd_src1_sel.
- stall_cnt  out  CNT_W  cycles with pc_enb=0.
- flush_cnt  out  CNT_W  redirects taken.

Behaviour:
- State machine: RUN, IMISS, DMISS. Reset state is RUN; drop_pend=0; both counters reset to 0.
- All control outputs are combinational from state and inputs. During rst they are forced as follows:
  - All enables = 1.
  - if_kill=1, dec_kill=1.
  - pc_sel=0, dec_nop_gen=0.
  - Forwarding selects = 00.
- Default in RUN: all enables = 1, no kill, no NOP, pc_sel=0.
- Condition priority, highest first: DMISS, redirect, load-use, IMISS.
- DMISS (dl1_req && !dl1_ack, or state DMISS):
  - All enables = 0; kills and pc_sel are suppressed.
  - Enter or stay in DMISS while !dl1_ack.
  - On the dl1_ack cycle, enables = 1 and the state returns to RUN.
  - A redirect pending in EXE is evaluated on the following cycle, because the pipeline was held.
- Redirect (redir = hz_exe_type==JUMP, or hz_exe_type==BRNCH && exe_brnch_taken):
  - pc_sel=1, if_kill=1, dec_kill=1.
  - flush_cnt increments.
  - Load-use is ignored in that cycle.
  - If the state is IMISS, set drop_pend=1 and keep pc_enb=1 so the target PC is captured.
- Load-use (hz_exe_type==LOAD && hz_exe_we && exe_rd!=0 && exe_rd matches dec_rs1 or dec_rs2):
  - pc_enb=0, if_enb=0, dec_nop_gen=1.
  - Exactly one bubble is inserted; the next cycle proceeds with WB forwarding.
- IMISS:
  - Entered from RUN when !il1_ack; stays while !il1_ack.
  - pc_enb=0, if_enb=0, dec_nop_gen=1. EXE, MEM and WB continue.
  - On il1_ack, return to RUN.
  - If drop_pend=1 on the il1_ack cycle, assert if_kill and clear drop_pend, so the stale fetch is discarded.
- Forwarding (for each EXE source, rs!=0):
  - 01 if hz_mem_we && hz_mem_rd==rs.
  - Otherwise 10 if hz_wb_we && hz_wb_rd==rs.
  - Otherwise 00.
  - MEM has priority over WB.
  - Forwarding selects are valid even while the pipeline is stalled.
- stall_cnt increments on every cycle with pc_enb=0.
- Both counters saturate at all-ones.
- A reset asserted during DMISS or IMISS returns the FSM to RUN and clears drop_pend on the next clock edge.

Decomposition:
- Shared package core_hazard_pkg holds:
  - HZRD_OTHER, HZRD_BRNCH, HZRD_JUMP, HZRD_LOAD codes.
  - FWD_RF, FWD_MEM, FWD_WB codes.
  - State enum: RUN, IMISS, DMISS.
  - Hazard bus field offsets.
- Sub-module core_hazard_fwd: purely combinational comparators for one source operand, instantiated twice.

Test Plan:
- Load-use hazard: exe={x,x,rd=5} type LOAD we=1, dec rs2=5 → for exactly one cycle pc_enb=0, if_enb=0, dec_nop_gen=1; stall_cnt increments 0→1.
- Forwarding priority: exe rs1=7, mem_rd=7 we=1, wb_rd=7 we=1 → fwd_src1_sel=01. Clear mem_we → 10. Set rs1=0 → 00.
- Taken branch: type BRNCH, exe_brnch_taken=1 → pc_sel=1, if_kill=1, dec_kill=1 for 1 cycle; flush_cnt=1. Same stimulus with taken=0 → no kill.
- Redirect during fetch miss: il1_ack=0 for 3 cycles, JUMP in EXE on cycle 2 → drop_pend set; if_kill=1 on the il1_ack cycle; state returns to RUN.
- Data miss overrides redirect: dl1_req=1, dl1_ack=0 for 4 cycles with JUMP in EXE → all enables 0 and pc_sel=0 throughout; redirect fires on the cycle after dl1_ack.
- Reset mid-DMISS: rst=1 for 1 cycle in DMISS → state RUN; counters 0; with all enables at 1 when rst deasserts.
